// File: rtl/sa_cache_ctrl.sv
// Miss/refill sequencer for the 4-way sa_cache: CPU valid/ready front end,
// dirty-line writeback, line fill from memory and replay of the original access.
module sa_cache_ctrl #(
  parameter int TAG_W    = 18,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 6,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic [31:0]         cpu_addr,
  input  logic                cpu_we,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_resp_valid,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_resp_err,
  output logic [TAG_W-1:0]    c_tag,
  output logic [INDEX_W-1:0]  c_index,
  output logic [OFFSET_W-1:0] c_offset,
  output logic [DATA_W-1:0]   c_dataW,
  output logic                c_memRW,
  output logic                c_access,
  input  logic [DATA_W-1:0]   c_data,
  input  logic                c_miss,
  input  logic                c_evict,
  input  logic [DATA_W-1:0]   c_evict_data,
  input  logic [31:0]         c_evict_addr,
  output logic [DATA_W-1:0]   c_mem_line,
  output logic                c_mem_response,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, REFILL, RESPOND
  } state_t;

  state_t                  state;
  logic [31-OFFSET_W:0]    req_line;
  logic                    req_we;
  logic                    replay;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [31:0]             fill_addr;
  logic                    progress;
  logic                    expire;

  assign fill_addr = {req_line, {OFFSET_W{1'b0}}};
  assign busy      = (state != IDLE);

  // A memory-phase state expires only when it made no progress this cycle.
  always_comb begin
    progress = 1'b1;
    case (state)
      WB_REQ, FILL_REQ:   progress = mem_req_ready;
      WB_WAIT, FILL_WAIT: progress = mem_resp_valid;
      default:            progress = 1'b1;
    endcase
    expire = !progress && (tmo_cnt == TMO_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      req_line       <= '0;
      req_we         <= 1'b0;
      replay         <= 1'b0;
      tmo_cnt        <= '0;
      cpu_req_ready  <= 1'b1;
      cpu_resp_valid <= 1'b0;
      cpu_rdata      <= '0;
      cpu_resp_err   <= 1'b0;
      c_tag          <= '0;
      c_index        <= '0;
      c_offset       <= '0;
      c_dataW        <= '0;
      c_memRW        <= 1'b0;
      c_access       <= 1'b0;
      c_mem_line     <= '0;
      c_mem_response <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      c_access       <= 1'b0;
      c_mem_response <= 1'b0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req_valid && cpu_req_ready) begin
            req_line      <= cpu_addr[31:OFFSET_W];
            req_we        <= cpu_we;
            replay        <= 1'b0;
            c_tag         <= cpu_addr[OFFSET_W+INDEX_W +: TAG_W];
            c_index       <= cpu_addr[OFFSET_W +: INDEX_W];
            c_offset      <= cpu_addr[OFFSET_W-1:0];
            c_dataW       <= cpu_wdata;
            c_memRW       <= cpu_we;
            c_access      <= 1'b1;
            cpu_req_ready <= 1'b0;
            state         <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!c_miss) begin
            cpu_resp_valid <= 1'b1;
            cpu_rdata      <= req_we ? '0 : c_data;
            state          <= RESPOND;
          end else if (replay) begin
            cpu_resp_valid <= 1'b1;
            cpu_resp_err   <= 1'b1;
            cpu_rdata      <= '0;
            state          <= RESPOND;
          end else if (c_evict) begin
            mem_req_valid <= 1'b1;
            mem_we        <= 1'b1;
            mem_addr      <= c_evict_addr;
            mem_wdata     <= c_evict_data;
            tmo_cnt       <= '0;
            state         <= WB_REQ;
          end else begin
            mem_req_valid <= 1'b1;
            mem_we        <= 1'b0;
            mem_addr      <= fill_addr;
            tmo_cnt       <= '0;
            state         <= FILL_REQ;
          end
        end
        WB_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            tmo_cnt       <= '0;
            state         <= WB_WAIT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WB_WAIT: begin
          if (mem_resp_valid) begin
            mem_req_valid <= 1'b1;
            mem_we        <= 1'b0;
            mem_addr      <= fill_addr;
            mem_wdata     <= '0;
            tmo_cnt       <= '0;
            state         <= FILL_REQ;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        FILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            tmo_cnt       <= '0;
            state         <= FILL_WAIT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        FILL_WAIT: begin
          if (mem_resp_valid) begin
            c_mem_line     <= mem_rdata;
            c_mem_response <= 1'b1;
            state          <= REFILL;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        REFILL: begin
          c_access <= 1'b1;
          replay   <= 1'b1;
          state    <= LOOKUP;
        end
        RESPOND: begin
          cpu_rdata     <= '0;
          cpu_req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Abort overrides whatever the memory-phase branch above scheduled.
      if (expire) begin
        mem_req_valid  <= 1'b0;
        mem_we         <= 1'b0;
        cpu_resp_valid <= 1'b1;
        cpu_resp_err   <= 1'b1;
        cpu_rdata      <= '0;
        state          <= RESPOND;
      end
    end
  end

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Directed bench for sa_cache_ctrl: drives the cache and memory sides by hand
// and checks each handshake against hand-computed values.
module tb_sa_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid, cpu_req_ready, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_resp_valid, cpu_resp_err;
  logic [17:0] c_tag;
  logic [7:0]  c_index;
  logic [5:0]  c_offset;
  logic [31:0] c_dataW, c_data, c_evict_data, c_evict_addr, c_mem_line;
  logic        c_memRW, c_access, c_miss, c_evict, c_mem_response;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  sa_cache_ctrl #(.TAG_W(18), .INDEX_W(8), .OFFSET_W(6), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata), .cpu_resp_err(cpu_resp_err),
    .c_tag(c_tag), .c_index(c_index), .c_offset(c_offset), .c_dataW(c_dataW),
    .c_memRW(c_memRW), .c_access(c_access), .c_data(c_data), .c_miss(c_miss),
    .c_evict(c_evict), .c_evict_data(c_evict_data), .c_evict_addr(c_evict_addr),
    .c_mem_line(c_mem_line), .c_mem_response(c_mem_response),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request in IDLE; returns with the DUT in LOOKUP and valid dropped.
  task automatic accept(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    cpu_addr      = addr;
    cpu_we        = we;
    cpu_wdata     = wdata;
    cpu_req_valid = 1'b1;
    tick();
    cpu_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    cpu_req_valid = 0; cpu_addr = '0; cpu_we = 0; cpu_wdata = '0;
    c_data = '0; c_miss = 0; c_evict = 0; c_evict_data = '0; c_evict_addr = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b1;
    check("rst_ready", 32'(cpu_req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_memvalid", 32'(mem_req_valid), 32'd0);
    check("rst_resp", 32'(cpu_resp_valid), 32'd0);

    // Hit load
    c_miss = 0; c_data = 32'h1234_5678;
    accept(32'h0000_4040, 1'b0, 32'h0);
    check("hit_access", 32'(c_access), 32'd1);
    check("hit_tag", 32'(c_tag), 32'h1);
    check("hit_index", 32'(c_index), 32'h01);
    check("hit_ready_busy", 32'(cpu_req_ready), 32'd0);
    tick();
    check("hit_resp_valid", 32'(cpu_resp_valid), 32'd1);
    check("hit_rdata", cpu_rdata, 32'h1234_5678);
    check("hit_err", 32'(cpu_resp_err), 32'd0);
    tick();
    check("hit_idle_resp", 32'(cpu_resp_valid), 32'd0);
    check("hit_idle_ready", 32'(cpu_req_ready), 32'd1);

    // Clean load miss; request held valid throughout, mem_resp pulse in FILL_REQ
    c_miss = 1; c_evict = 0;
    cpu_addr = 32'h0000_4047; cpu_we = 0; cpu_req_valid = 1'b1;
    tick();
    check("cm_offset", 32'(c_offset), 32'h07);
    tick();
    check("cm_req_valid", 32'(mem_req_valid), 32'd1);
    check("cm_we", 32'(mem_we), 32'd0);
    check("cm_addr", mem_addr, 32'h0000_4040);
    check("cm_ready_held", 32'(cpu_req_ready), 32'd0);
    mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_0000;
    tick();
    mem_resp_valid = 1'b0;
    check("cm_ignore_resp", 32'(mem_req_valid), 32'd1);
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("cm_wait_valid", 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_resp_valid = 1'b0;
    check("cm_mem_response", 32'(c_mem_response), 32'd1);
    check("cm_mem_line", c_mem_line, 32'hCAFE_F00D);
    c_miss = 0; c_data = 32'hCAFE_F00D;
    tick();
    check("cm_response_pulse", 32'(c_mem_response), 32'd0);
    check("cm_replay_access", 32'(c_access), 32'd1);
    tick();
    cpu_req_valid = 1'b0;
    check("cm_resp_valid", 32'(cpu_resp_valid), 32'd1);
    check("cm_rdata", cpu_rdata, 32'hCAFE_F00D);
    check("cm_err", 32'(cpu_resp_err), 32'd0);
    tick();

    // Store miss with dirty eviction: writeback then fill
    c_miss = 1; c_evict = 1; c_data = 32'h0000_0055;
    c_evict_addr = 32'h8000_0100; c_evict_data = 32'hA5A5_A5A5;
    accept(32'h0000_8084, 1'b1, 32'hDEAD_BEEF);
    check("st_memrw", 32'(c_memRW), 32'd1);
    check("st_dataw", c_dataW, 32'hDEAD_BEEF);
    tick();
    check("wb_valid", 32'(mem_req_valid), 32'd1);
    check("wb_we", 32'(mem_we), 32'd1);
    check("wb_addr", mem_addr, 32'h8000_0100);
    check("wb_wdata", mem_wdata, 32'hA5A5_A5A5);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("wb_wait_valid", 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    check("st_fill_valid", 32'(mem_req_valid), 32'd1);
    check("st_fill_we", 32'(mem_we), 32'd0);
    check("st_fill_addr", mem_addr, 32'h0000_8080);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_resp_valid = 1'b0;
    check("st_line", c_mem_line, 32'h1111_2222);
    c_miss = 0; c_evict = 0;
    tick();
    tick();
    check("st_resp_valid", 32'(cpu_resp_valid), 32'd1);
    check("st_rdata", cpu_rdata, 32'h0);
    tick();

    // Memory never ready: timeout after TIMEOUT cycles in FILL_REQ
    c_miss = 1;
    accept(32'h0000_1000, 1'b0, 32'h0);
    tick();
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (cpu_resp_valid) break;
      if (mem_req_valid) n++;
      tick();
    end
    check("to_resp_valid", 32'(cpu_resp_valid), 32'd1);
    check("to_cycles", 32'(n), 32'd255);
    check("to_err", 32'(cpu_resp_err), 32'd1);
    check("to_rdata", cpu_rdata, 32'h0);
    check("to_memvalid", 32'(mem_req_valid), 32'd0);
    // Next request, raised while still busy, is taken only once IDLE
    c_miss = 0; c_data = 32'h0BAD_F00D;
    cpu_addr = 32'h0000_2000; cpu_we = 0; cpu_req_valid = 1'b1;
    tick();
    check("to_idle_busy", 32'(busy), 32'd0);
    check("to_err_clear", 32'(cpu_resp_err), 32'd0);
    tick();
    cpu_req_valid = 1'b0;
    check("nx_busy", 32'(busy), 32'd1);
    tick();
    check("nx_rdata", cpu_rdata, 32'h0BAD_F00D);
    check("nx_err", 32'(cpu_resp_err), 32'd0);
    tick();

    // Miss again after refill: error response
    c_miss = 1;
    accept(32'h0000_3000, 1'b0, 32'h0);
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    tick();
    check("rm_resp_valid", 32'(cpu_resp_valid), 32'd1);
    check("rm_err", 32'(cpu_resp_err), 32'd1);
    tick();

    // Reset in FILL_WAIT abandons the transaction
    accept(32'h0000_5000, 1'b0, 32'h0);
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b0;
    tick(); tick();
    check("mr_ready", 32'(cpu_req_ready), 32'd1);
    check("mr_memvalid", 32'(mem_req_valid), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    check("mr_no_resp", 32'(cpu_resp_valid), 32'd0);
    check("mr_no_line", 32'(c_mem_response), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
